// File: rtl/event_timestamper_to.sv
`default_nettype none
// ============================================================================
//  Module   : event_timestamper_to
//  Purpose  : Pairs start/end events by ID against a free-running counter and
//             emits latency records through a show-ahead output FIFO. When the
//             EVT_TS_TIMEOUT_EN macro is defined, a round-robin scanner evicts
//             IDs that stayed in flight for TIMEOUT cycles or more. Each
//             eviction produces a record flagged out_timeout=1.
//  Ports    : clk, rst_n          - clock, asynchronous active-low reset
//             start_valid/ready/id - start event handshake
//             end_valid/ready/id   - end event handshake
//             out_valid/ready      - record handshake (FIFO head)
//             out_id/start_ts/end_ts/ts/timeout - record fields
//             inflight_cnt         - number of active IDs
//             timeout_cnt          - saturating eviction count
//  Config   : `define EVT_TS_TIMEOUT_EN to build the timeout scanner
//  Revision : 1.0 - initial release
// ============================================================================
module event_timestamper_to #(
    parameter int ID_W      = 4,
    parameter int TS_W      = 64,
    parameter int OUT_DEPTH = 4,
    parameter int TIMEOUT   = 1000,
    parameter int STAT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [ID_W-1:0]   start_id,
    input  logic              end_valid,
    output logic              end_ready,
    input  logic [ID_W-1:0]   end_id,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ID_W-1:0]   out_id,
    output logic [TS_W-1:0]   out_start_ts,
    output logic [TS_W-1:0]   out_end_ts,
    output logic [TS_W-1:0]   out_ts,
    output logic              out_timeout,
    output logic [ID_W:0]     inflight_cnt,
    output logic [STAT_W-1:0] timeout_cnt
);

    localparam int c_NUM_IDS = 2 ** ID_W;
    localparam int c_PTR_W   = $clog2(OUT_DEPTH);
    localparam logic [c_PTR_W:0] c_DEPTH = (c_PTR_W + 1)'(OUT_DEPTH);

    // Elaboration-time parameter sanity checks
    if (OUT_DEPTH < 2 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0) begin : g_chk_out_depth
        $error("OUT_DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT < 1) begin : g_chk_timeout
        $error("TIMEOUT must be >= 1");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [TS_W-1:0]      r_cnt;
    logic [c_NUM_IDS-1:0] r_active;
    logic [TS_W-1:0]      r_start_mem [c_NUM_IDS];
    logic [ID_W:0]        r_inflight;

    logic [ID_W-1:0]      r_fifo_id    [OUT_DEPTH];
    logic [TS_W-1:0]      r_fifo_start [OUT_DEPTH];
    logic [TS_W-1:0]      r_fifo_end   [OUT_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic                 w_pop;
    logic                 w_fifo_space;
    logic                 w_end_fire;
    logic                 w_start_fire;
    logic                 w_evict;
    logic [ID_W-1:0]      w_evict_id;
    logic                 w_push;
    logic [ID_W-1:0]      w_push_id;
    logic [TS_W-1:0]      w_push_start;
    logic [c_NUM_IDS-1:0] w_active_nxt;

    assign out_valid    = (r_count != '0);
    assign w_pop        = out_valid && out_ready;
    // A pop in the same cycle frees the slot the push needs, even when full.
    assign w_fifo_space = (r_count < c_DEPTH) || w_pop;

    assign end_ready    = r_active[end_id] && w_fifo_space;
    assign w_end_fire   = end_valid && end_ready;

    // End wins a same-ID collision; the start simply retries next cycle.
    assign start_ready  = !r_active[start_id] && !(w_end_fire && (end_id == start_id));
    assign w_start_fire = start_valid && start_ready;

    // One push per cycle; an end event pre-empts the scanner.
    assign w_push       = w_end_fire || w_evict;
    assign w_push_id    = w_end_fire ? end_id : w_evict_id;
    assign w_push_start = r_start_mem[w_push_id];

`ifdef EVT_TS_TIMEOUT_EN
    // ------------------------------------------------------------------
    // Timeout scanner: visits one ID per cycle in round-robin order
    // ------------------------------------------------------------------
    localparam logic [TS_W-1:0] c_TIMEOUT = TS_W'(TIMEOUT);

    logic [ID_W-1:0]      r_scan_ptr;
    logic [OUT_DEPTH-1:0] r_fifo_to;
    logic [STAT_W-1:0]    r_timeout_cnt;
    logic [TS_W-1:0]      w_scan_delta;
    logic                 w_scan_due;

    assign w_scan_delta = r_cnt - r_start_mem[r_scan_ptr];
    assign w_scan_due   = r_active[r_scan_ptr] && (w_scan_delta >= c_TIMEOUT);
    assign w_evict      = w_scan_due && w_fifo_space && !w_end_fire;
    assign w_evict_id   = r_scan_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_ptr    <= '0;
            r_fifo_to     <= '0;
            r_timeout_cnt <= '0;
        end else begin
            // Hold on a blocked eviction so the stale ID is not skipped.
            if (!(w_scan_due && !w_evict)) begin
                r_scan_ptr <= r_scan_ptr + 1'b1;
            end
            if (w_push) begin
                r_fifo_to[r_wr_ptr] <= !w_end_fire;
            end
            if (w_evict && (r_timeout_cnt != '1)) begin
                r_timeout_cnt <= r_timeout_cnt + 1'b1;
            end
        end
    end

    assign out_timeout = r_fifo_to[r_rd_ptr];
    assign timeout_cnt = r_timeout_cnt;
`else
    assign w_evict     = 1'b0;
    assign w_evict_id  = '0;
    assign out_timeout = 1'b0;
    assign timeout_cnt = '0;
`endif

    // ------------------------------------------------------------------
    // Active-set update. The three actions never target the same ID:
    // start needs the ID inactive, eviction needs it active, and an end
    // blocks a same-ID start.
    // ------------------------------------------------------------------
    always_comb begin
        w_active_nxt = r_active;
        if (w_end_fire) begin
            w_active_nxt[end_id] = 1'b0;
        end
        if (w_evict) begin
            w_active_nxt[w_evict_id] = 1'b0;
        end
        if (w_start_fire) begin
            w_active_nxt[start_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_active   <= '0;
            r_inflight <= '0;
            for (int i = 0; i < c_NUM_IDS; i++) begin
                r_start_mem[i] <= '0;
            end
        end else begin
            r_cnt    <= r_cnt + 1'b1;
            r_active <= w_active_nxt;
            if (w_start_fire) begin
                r_start_mem[start_id] <= r_cnt;
            end
            if (w_start_fire && !w_push) begin
                r_inflight <= r_inflight + 1'b1;
            end else if (!w_start_fire && w_push) begin
                r_inflight <= r_inflight - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead output FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                r_fifo_id[i]    <= '0;
                r_fifo_start[i] <= '0;
                r_fifo_end[i]   <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo_id[r_wr_ptr]    <= w_push_id;
                r_fifo_start[r_wr_ptr] <= w_push_start;
                r_fifo_end[r_wr_ptr]   <= r_cnt;
                r_wr_ptr               <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign out_id       = r_fifo_id[r_rd_ptr];
    assign out_start_ts = r_fifo_start[r_rd_ptr];
    assign out_end_ts   = r_fifo_end[r_rd_ptr];
    // Modular difference: correct across one counter wrap.
    assign out_ts       = out_end_ts - out_start_ts;
    assign inflight_cnt = r_inflight;

endmodule
`default_nettype wire
